// File: rtl/phase_request_scheduler.sv
// Front-end scheduler for the intersection controller: debounces four raw request
// inputs, latches them as pending requests and offers one phase at a time.
module phase_request_scheduler #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_WAIT_CYCLES = 1000,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ns_sensor,
    input  logic       ew_sensor,
    input  logic       pd_button_ns,
    input  logic       pd_button_ew,
    input  logic       phase_ready,
    input  logic       phase_done,
    output logic       phase_valid,
    output logic [1:0] phase_sel,
    output logic [3:0] pending,
    output logic       starve_flag,
    output logic [1:0] state_dbg
);
    // Handshake: phase_valid/phase_sel stay stable until an edge sees phase_valid &&
    // phase_ready; phase_valid drops the next cycle and the phase is held until phase_done.

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OFFER = 2'd1;
    localparam logic [1:0] ST_BUSY  = 2'd2;

    localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [3:0]       raw_in;
    logic [3:0]       sync1_q, sync1_d, sync2_q, sync2_d;
    logic [CNT_W-1:0] deb_q  [4];
    logic [CNT_W-1:0] deb_d  [4];
    logic [3:0]       evt_q, evt_d;
    logic [3:0]       pend_q, pend_d, rearm_q, rearm_d;
    logic [CNT_W-1:0] wait_q [4];
    logic [CNT_W-1:0] wait_d [4];
    logic             starve_q, starve_d;
    logic [1:0]       state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       ptr_q, ptr_d;
    logic             valid_q, valid_d;
    logic [3:0]       starved;
    logic [1:0]       pick, scan_idx;
    logic             found, done_fire, hold_age;

    assign raw_in = {pd_button_ew, pd_button_ns, ew_sensor, ns_sensor};

    // The event is registered so it lands on the cycle the counter first reads full.
    always_comb begin
        sync1_d = raw_in;
        sync2_d = sync1_q;
        for (int i = 0; i < 4; i++) begin
            if (!sync2_q[i]) begin
                deb_d[i] = '0;
            end else if (deb_q[i] == DEB_MAX) begin
                deb_d[i] = deb_q[i];
            end else begin
                deb_d[i] = deb_q[i] + CNT_ONE;
            end
            evt_d[i] = (deb_d[i] == DEB_MAX) && (deb_q[i] != DEB_MAX);
        end
    end

    always_comb begin
        starved  = '0;
        pick     = ptr_q;
        found    = 1'b0;
        scan_idx = ptr_q;
        for (int i = 0; i < 4; i++) begin
            starved[i] = pend_q[i] && (wait_q[i] == WAIT_MAX);
        end
        if (|starved) begin
            for (int i = 3; i >= 0; i--) begin
                if (starved[i]) pick = 2'(i);
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                scan_idx = ptr_q + 2'(i);
                if (!found && pend_q[scan_idx]) begin
                    pick  = scan_idx;
                    found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        done_fire = (state_q == ST_BUSY) && phase_done;
        case (state_q)
            ST_IDLE: begin
                if (|pend_q) begin
                    sel_d   = pick;
                    valid_d = 1'b1;
                    state_d = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (phase_ready) begin
                    valid_d = 1'b0;
                    ptr_d   = sel_q + 2'd1;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (phase_done) state_d = ST_IDLE;
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Set beats clear; a re-press of the granted phase is parked in rearm until done.
    always_comb begin
        pend_d   = pend_q;
        rearm_d  = rearm_q;
        hold_age = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (done_fire && (sel_q == 2'(i))) begin
                pend_d[i]  = rearm_q[i];
                rearm_d[i] = 1'b0;
            end
            if (evt_q[i]) begin
                pend_d[i] = 1'b1;
                if ((state_q == ST_BUSY) && (sel_q == 2'(i)) && !done_fire) rearm_d[i] = 1'b1;
            end
            hold_age = (state_q == ST_BUSY) && (sel_q == 2'(i));
            if (!pend_d[i]) begin
                wait_d[i] = '0;
            end else if (pend_q[i] && !hold_age && (wait_q[i] != WAIT_MAX)) begin
                wait_d[i] = wait_q[i] + CNT_ONE;
            end else begin
                wait_d[i] = wait_q[i];
            end
        end
        starve_d = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (wait_d[i] == WAIT_MAX) starve_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            evt_q    <= '0;
            pend_q   <= '0;
            rearm_q  <= '0;
            starve_q <= 1'b0;
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            ptr_q    <= '0;
            valid_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                deb_q[i]  <= '0;
                wait_q[i] <= '0;
            end
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            evt_q    <= evt_d;
            pend_q   <= pend_d;
            rearm_q  <= rearm_d;
            starve_q <= starve_d;
            state_q  <= state_d;
            sel_q    <= sel_d;
            ptr_q    <= ptr_d;
            valid_q  <= valid_d;
            for (int i = 0; i < 4; i++) begin
                deb_q[i]  <= deb_d[i];
                wait_q[i] <= wait_d[i];
            end
        end
    end

    assign phase_valid = valid_q;
    assign phase_sel   = sel_q;
    assign pending     = pend_q;
    assign starve_flag = starve_q;
    assign state_dbg   = state_q;

endmodule
